// File: rtl/mem_access_if.sv
// Bundle of the execute-side, data-memory and writeback handshakes seen by mem_access.
interface mem_access_if #(parameter int unsigned XLEN = 32);
  logic            valid;
  logic            ready;
  logic            mem_op;
  logic            store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [4:0]      rd_addr;
  logic            rd_wen;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd_addr;
  logic            wb_rd_wen;
  logic            misaligned;
  logic            illegal;

  modport slave (
    input  valid, mem_op, store, funct3, addr, wdata, rd_addr, rd_wen,
           dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
    output ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_data, wb_rd_addr, wb_rd_wen, misaligned, illegal
  );

  modport master (
    output valid, mem_op, store, funct3, addr, wdata, rd_addr, rd_wen,
           dmem_gnt, dmem_rvalid, dmem_rdata, wb_ready,
    input  ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
           wb_valid, wb_data, wb_rd_addr, wb_rd_wen, misaligned, illegal
  );
endinterface

// File: rtl/mem_access.sv
// Memory/writeback stage: one instruction at a time, byte-lane loads/stores over
// a req/gnt/rvalid port, and a single writeback beat per instruction.
module mem_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_access_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;

  state_t          state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            wen_q;

  logic            is_ill;
  logic            is_mis;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_d;

  always_comb begin
    is_ill  = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
              (bus.store && bus.funct3[2]);
    is_mis  = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
              ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    be_d    = 4'b1111;
    wdata_d = bus.wdata;
    if (bus.store) begin
      case (bus.funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << bus.addr[1:0];
          wdata_d = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          be_d    = bus.addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{bus.wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Lane select uses the offset captured at accept, since the input address is gone by RESP.
  always_comb begin
    byte_sel = bus.dmem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_d = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_d = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  load_d = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  load_d = {{(XLEN-16){1'b0}}, half_sel};
      default: load_d = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      bus.ready      <= 1'b1;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.dmem_be    <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_data    <= '0;
      bus.wb_rd_addr <= '0;
      bus.wb_rd_wen  <= 1'b0;
      bus.misaligned <= 1'b0;
      bus.illegal    <= 1'b0;
      f3_q           <= '0;
      off_q          <= '0;
      wen_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            bus.ready      <= 1'b0;
            bus.wb_rd_addr <= bus.rd_addr;
            bus.wb_data    <= '0;
            bus.wb_rd_wen  <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
            f3_q           <= bus.funct3;
            off_q          <= bus.addr[1:0];
            wen_q          <= bus.rd_wen && (bus.rd_addr != '0);
            if (!bus.mem_op) begin
              bus.wb_data   <= bus.addr;
              bus.wb_rd_wen <= bus.rd_wen && (bus.rd_addr != '0);
              bus.wb_valid  <= 1'b1;
              state         <= WB;
            end else if (is_ill) begin
              bus.illegal  <= 1'b1;
              bus.wb_valid <= 1'b1;
              state        <= WB;
            end else if (is_mis) begin
              bus.misaligned <= 1'b1;
              bus.wb_valid   <= 1'b1;
              state          <= WB;
            end else begin
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= bus.store;
              bus.dmem_addr  <= {bus.addr[XLEN-1:2], 2'b00};
              bus.dmem_be    <= be_d;
              bus.dmem_wdata <= wdata_d;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.dmem_gnt) begin
            bus.dmem_req <= 1'b0;
            if (bus.dmem_we) begin
              bus.wb_rd_wen <= 1'b0;
              bus.wb_valid  <= 1'b1;
              state         <= WB;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.dmem_rvalid) begin
            bus.wb_data   <= load_d;
            bus.wb_rd_wen <= wen_q;
            bus.wb_valid  <= 1'b1;
            state         <= WB;
          end
        end
        WB: begin
          if (bus.wb_ready) begin
            bus.wb_valid   <= 1'b0;
            bus.wb_rd_wen  <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.ready      <= 1'b1;
            state          <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model of the
// expected memory request and writeback beat for each instruction.
module tb_mem_access;

  logic clk;
  logic rst;
  mem_access_if bus ();

  mem_access dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wbd;
    bit          chk_data;
    logic [4:0]  rd;
    bit          wen;
    bit          mis;
    bit          ill;
  } exp_t;

  exp_t m;
  bit   m_idle = 1'b1;
  bit   cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected behaviour derived from the instruction fields alone.
  function automatic exp_t model(input bit mem, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdata, input logic [4:0] rd,
                                 input bit wen);
    exp_t e;
    int unsigned size;
    int unsigned sh;
    logic [31:0] mask;
    logic [31:0] v;
    size = int'(f3[1:0]);
    e.ill = mem && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3[2]));
    e.mis = mem && !e.ill && ((size == 1 && a[0]) || (size == 2 && a[1:0] != 2'd0));
    e.req = mem && !e.ill && !e.mis;
    e.we = st;
    e.addr = a & 32'hFFFF_FFFC;
    e.wdata = wd;
    e.be = 4'hF;
    if (st && size == 0) begin
      e.be = 4'(1 << a[1:0]);
      e.wdata = {24'h0, wd[7:0]} * 32'h0101_0101;
    end else if (st && size == 1) begin
      e.be = 4'(3 << (a[1] ? 2 : 0));
      e.wdata = {16'h0, wd[15:0]} * 32'h0001_0001;
    end
    e.rd = rd;
    e.chk_data = !mem || (e.req && !st);
    e.wbd = a;
    if (mem) begin
      if (size == 0) begin sh = 8 * a[1:0]; mask = 32'hFF; end
      else if (size == 1) begin sh = a[1] ? 16 : 0; mask = 32'hFFFF; end
      else begin sh = 0; mask = 32'hFFFF_FFFF; end
      v = (rdata >> sh) & mask;
      if (!f3[2] && size < 2 && ((v & ~(mask >> 1)) != 0)) v = v | ~mask;
      e.wbd = v;
    end
    e.wen = (!mem || (e.req && !st)) && wen && (rd != 5'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      if (m_idle) begin
        chk("idle_ready", 32'(bus.ready), 32'd1);
        chk("idle_req", 32'(bus.dmem_req), 32'd0);
        chk("idle_wb_valid", 32'(bus.wb_valid), 32'd0);
      end else begin
        chk("busy_ready", 32'(bus.ready), 32'd0);
        if (!m.req) chk("no_req", 32'(bus.dmem_req), 32'd0);
        else if (bus.dmem_req) begin
          chk("req_addr", bus.dmem_addr, m.addr);
          chk("req_we", 32'(bus.dmem_we), 32'(m.we));
          chk("req_be", 32'(bus.dmem_be), 32'(m.be));
          if (m.we) chk("req_wdata", bus.dmem_wdata, m.wdata);
        end
        if (bus.wb_valid) begin
          if (m.chk_data) chk("wb_data", bus.wb_data, m.wbd);
          chk("wb_rd_addr", 32'(bus.wb_rd_addr), 32'(m.rd));
          chk("wb_rd_wen", 32'(bus.wb_rd_wen), 32'(m.wen));
          chk("wb_misaligned", 32'(bus.misaligned), 32'(m.mis));
          chk("wb_illegal", 32'(bus.illegal), 32'(m.ill));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.dmem_rvalid = ($urandom_range(0, 2) == 0);
    bus.dmem_rdata  = $urandom;
  endtask

  task automatic do_txn(input bit mem, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdata, input logic [4:0] rd, input bit wen,
                        input int unsigned gdly, input int unsigned rdly,
                        input int unsigned stall, input bit lit_en,
                        input logic [31:0] lit);
    m = model(mem, st, f3, a, wd, rdata, rd, wen);
    bus.valid = 1'b1;  bus.mem_op = mem;  bus.store = st;  bus.funct3 = f3;
    bus.addr = a;  bus.wdata = wd;  bus.rd_addr = rd;  bus.rd_wen = wen;
    chk("accept_ready", 32'(bus.ready), 32'd1);
    tick();
    m_idle = 1'b0;
    bus.valid = 1'b0;
    bus.addr = $urandom;  bus.wdata = $urandom;  bus.funct3 = 3'($urandom);
    if (!m.req) begin
      chk("lat_wb_direct", 32'(bus.wb_valid), 32'd1);
    end else begin
      for (int unsigned k = 0; k < gdly; k++) begin
        chk("req_held", 32'(bus.dmem_req), 32'd1);
        noise();
        tick();
      end
      bus.dmem_rvalid = 1'b0;
      chk("req_at_gnt", 32'(bus.dmem_req), 32'd1);
      bus.dmem_gnt = 1'b1;
      tick();
      bus.dmem_gnt = 1'b0;
      chk("req_drop", 32'(bus.dmem_req), 32'd0);
      if (st) begin
        chk("lat_store_wb", 32'(bus.wb_valid), 32'd1);
      end else begin
        for (int unsigned k = 1; k < rdly; k++) begin
          chk("resp_wait", 32'(bus.wb_valid), 32'd0);
          tick();
        end
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata = rdata;
        tick();
        bus.dmem_rvalid = 1'b0;
        chk("lat_load_wb", 32'(bus.wb_valid), 32'd1);
      end
    end
    if (lit_en) chk("wb_data_literal", bus.wb_data, lit);
    for (int unsigned k = 0; k < stall; k++) begin
      bus.wb_ready = 1'b0;
      noise();
      tick();
      chk("wb_stall", 32'(bus.wb_valid), 32'd1);
    end
    bus.dmem_rvalid = 1'b0;
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    m_idle = 1'b1;
    chk("wb_done", 32'(bus.wb_valid), 32'd0);
    chk("ready_back", 32'(bus.ready), 32'd1);
  endtask

  task automatic reset_mid(input bit in_resp);
    m = model(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 5'd7, 1'b1);
    bus.valid = 1'b1;  bus.mem_op = 1'b1;  bus.store = 1'b0;  bus.funct3 = 3'b010;
    bus.addr = 32'h0000_3000;  bus.rd_addr = 5'd7;  bus.rd_wen = 1'b1;
    tick();
    m_idle = 1'b0;
    bus.valid = 1'b0;
    chk("rst_pre_req", 32'(bus.dmem_req), 32'd1);
    if (in_resp) begin
      bus.dmem_gnt = 1'b1;
      tick();
      bus.dmem_gnt = 1'b0;
    end
    cmp_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_req_drop", 32'(bus.dmem_req), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    tick();
    rst = 1'b0;
    m_idle = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.dmem_rvalid = 1'b0;
    cmp_en = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      chk("rst_no_wb", 32'(bus.wb_valid), 32'd0);
      tick();
    end
  endtask

  exp_t p;

  initial begin
    rst = 1'b1;
    bus.valid = 1'b0;  bus.mem_op = 1'b0;  bus.store = 1'b0;  bus.funct3 = '0;
    bus.addr = '0;  bus.wdata = '0;  bus.rd_addr = '0;  bus.rd_wen = 1'b0;
    bus.dmem_gnt = 1'b0;  bus.dmem_rvalid = 1'b0;  bus.dmem_rdata = '0;
    bus.wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_dmem_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_be", 32'(bus.dmem_be), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd_addr), 32'd0);
    chk("rst_wb_wen", 32'(bus.wb_rd_wen), 32'd0);
    chk("rst_mis", 32'(bus.misaligned), 32'd0);
    chk("rst_ill", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    tick();
    cmp_en = 1'b1;

    p = model(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h8011_2233, 5'd1, 1'b1);
    chk("pin_lb_addr", p.addr, 32'h0000_1000);
    chk("pin_lb_data", p.wbd, 32'hFFFF_FF80);
    p = model(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'hBEEF_1234, 5'd1, 1'b1);
    chk("pin_lhu_data", p.wbd, 32'h0000_BEEF);
    p = model(1'b1, 1'b1, 3'b000, 32'h101, 32'hA5, 32'h0, 5'd1, 1'b1);
    chk("pin_sb_be", 32'(p.be), 32'h2);
    chk("pin_sb_wdata", p.wdata, 32'hA5A5_A5A5);
    chk("pin_sb_wen", 32'(p.wen), 32'd0);

    do_txn(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 5'd5, 1'b1, 0, 1, 3, 1'b1, 32'h1234_5678);
    do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8011_2233, 5'd3, 1'b1, 0, 1, 0, 1'b1, 32'hFFFF_FF80);
    do_txn(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8011_2233, 5'd3, 1'b1, 0, 1, 0, 1'b1, 32'h0000_0080);
    do_txn(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 5'd4, 1'b1, 0, 1, 1, 1'b1, 32'h0000_BEEF);
    do_txn(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h7FFF_8001, 5'd4, 1'b1, 0, 2, 0, 1'b1, 32'hFFFF_8001);
    do_txn(1'b1, 1'b1, 3'b000, 32'h0000_0101, 32'hA5, 32'h0, 5'd6, 1'b1, 2, 1, 0, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 5'd6, 1'b1, 0, 1, 1, 1'b0, 32'h0);
    do_txn(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 5'd6, 1'b1, 0, 1, 1, 1'b0, 32'h0);
    do_txn(1'b0, 1'b0, 3'b000, 32'hCAFE_F00D, 32'h0, 32'h0, 5'd0, 1'b1, 0, 1, 0, 1'b1, 32'hCAFE_F00D);

    reset_mid(1'b1);
    reset_mid(1'b0);
    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_3004, 32'h0, 32'h1357_9BDF, 5'd9, 1'b1, 1, 1, 0, 1'b1, 32'h1357_9BDF);

    for (int unsigned i = 0; i < 200; i++) begin
      bit          mem;
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [4:0]  rd;
      mem = ($urandom_range(0, 3) != 0);
      st  = $urandom_range(0, 1) == 1;
      f3  = ($urandom_range(0, 4) == 0) ? 3'($urandom) :
            (st ? 3'($urandom_range(0, 2)) : 3'(($urandom_range(0, 1) << 2) | $urandom_range(0, 2)));
      a   = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : (f3[1:0] == 2'b01 ? {a[1], 1'b0} : a[1:0]);
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      do_txn(mem, st, f3, a, $urandom, $urandom, rd, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3), 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) begin
        noise();
        tick();
      end
      bus.dmem_rvalid = 1'b0;
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
